// File: rtl/ara_perf_pkg.sv
// Shared state encoding, default counter width and read-index map for the
// Ara measurement-window controller.
package ara_perf_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, RUN} perf_state_e;

   localparam int unsigned DefCntWidth = 64;
   typedef logic [DefCntWidth-1:0] cnt_t;

   localparam int unsigned IdxRuntime = 0;
   localparam int unsigned IdxEvt0    = 1;

   // The update count sits right after the last event counter.
   function automatic int unsigned idx_upd_cnt(int unsigned nr_events);
      return nr_events + 1;
   endfunction

endpackage

// File: rtl/ara_perf_window_ctrl_counter.sv
// Saturating up-counter; exposes the value including this cycle's increment
// so a snapshot taken on the same edge sees the current cycle.
module ara_sat_counter #(
   parameter int unsigned Width = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [Width-1:0] nxt
);

   logic [Width-1:0] cnt;

   assign nxt = (en && cnt != '1) ? cnt + 1'b1 : cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else               cnt <= nxt;
   end

endmodule

// File: rtl/ara_perf_window_ctrl.sv
// Measurement-window controller for Ara runtime and CVA6 stall counters.
// Define ARA_PERF_TRIGGER_EN to drive trigger_o on window open/close.
module ara_perf_window_ctrl
   import ara_perf_pkg::*;
#(
   parameter int unsigned NrEvents = 3,
   parameter int unsigned CntWidth = DefCntWidth,
   parameter int unsigned IdleHold = 2,
   parameter int unsigned IdxWidth = $clog2(NrEvents + 2)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                sw_en_i,
   input  logic                vinsn_valid_i,
   input  logic                ara_idle_i,
   input  logic [NrEvents-1:0] event_i,
   input  logic                clear_i,
   input  logic                rd_req_i,
   input  logic [IdxWidth-1:0] rd_idx_i,
   output logic                rd_valid_o,
   output logic [CntWidth-1:0] rd_data_o,
   output logic                rd_err_o,
   output logic                window_active_o,
   output logic                snapshot_valid_o,
   output logic                trigger_o
);

   localparam int unsigned IdxUpd = idx_upd_cnt(NrEvents);
   localparam int unsigned IdleW  = $clog2(IdleHold + 1);

   perf_state_e state, state_nxt;
   logic [IdleW-1:0] idle_cnt;
   logic run, pending, drained, latch;
   logic [NrEvents+1:0][CntWidth-1:0] snap_d, snap;

   assign run     = (state == RUN);
   assign drained = (idle_cnt >= IdleW'(IdleHold));
   // A dispatch in the drain cycle means the pipeline is not really empty.
   assign latch   = pending & drained & ~vinsn_valid_i;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sw_en_i) state_nxt = ARMED;
         ARMED:   if (!sw_en_i) state_nxt = IDLE;
                  else if (vinsn_valid_i) state_nxt = RUN;
         RUN:     if (!sw_en_i && ara_idle_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   ara_sat_counter #(.Width(CntWidth)) u_runtime (
      .clk(clk_i), .rst_n(rst_ni), .clr(clear_i), .en(run), .nxt(snap_d[IdxRuntime])
   );

   for (genvar k = 0; k < NrEvents; k++) begin : g_evt
      ara_sat_counter #(.Width(CntWidth)) u_evt (
         .clk(clk_i), .rst_n(rst_ni), .clr(clear_i), .en(run & event_i[k]),
         .nxt(snap_d[IdxEvt0 + k])
      );
   end

   ara_sat_counter #(.Width(CntWidth)) u_upd (
      .clk(clk_i), .rst_n(rst_ni), .clr(clear_i), .en(latch), .nxt(snap_d[IdxUpd])
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state            <= IDLE;
         idle_cnt         <= '0;
         pending          <= 1'b0;
         snap             <= '0;
         snapshot_valid_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!ara_idle_i)  idle_cnt <= '0;
         else if (!drained) idle_cnt <= idle_cnt + 1'b1;
         if (vinsn_valid_i) pending <= 1'b1;
         else if (latch)    pending <= 1'b0;
         if (latch) begin
            snap             <= snap_d;
            snapshot_valid_o <= 1'b1;
         end
      end
   end

   // Reads see the registered snapshots, so a same-cycle latch returns old data.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         rd_valid_o <= 1'b0;
         rd_err_o   <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         rd_valid_o <= rd_req_i;
         rd_err_o   <= 1'b0;
         if (rd_req_i) begin
            if (rd_idx_i > IdxWidth'(IdxUpd)) begin
               rd_data_o <= '0;
               rd_err_o  <= 1'b1;
            end else begin
               rd_data_o <= snap[rd_idx_i];
            end
         end
      end
   end

   assign window_active_o = run;

`ifdef ARA_PERF_TRIGGER_EN
   logic trig;
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) trig <= 1'b0;
      else trig <= (state == ARMED && state_nxt == RUN) ||
                   (state == RUN && state_nxt == IDLE);
   end
   assign trigger_o = trig;
`else
   assign trigger_o = 1'b0;
`endif

endmodule

// File: tb/tb_ara_perf_window_ctrl.sv
// Scoreboard bench for ara_perf_window_ctrl: a behavioural model predicts read
// responses and status outputs; a monitor compares on every falling edge.
module tb_ara_perf_window_ctrl;

   localparam int NEV  = 3;
   localparam int CW   = 10;
   localparam int IW   = 3;
   localparam int NIDX = NEV + 2;
   localparam longint MAXV = (64'd1 << CW) - 1;

   logic clk, rst_n, sw_en, vinsn, ara_idle, clear, rd_req;
   logic [NEV-1:0] ev;
   logic [IW-1:0] rd_idx;
   logic rd_valid, rd_err, win, snapv, trig;
   logic [CW-1:0] rd_data;

   ara_perf_window_ctrl #(.NrEvents(NEV), .CntWidth(CW), .IdleHold(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .vinsn_valid_i(vinsn),
      .ara_idle_i(ara_idle), .event_i(ev), .clear_i(clear), .rd_req_i(rd_req),
      .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .rd_err_o(rd_err), .window_active_o(win), .snapshot_valid_o(snapv),
      .trigger_o(trig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { bit err; longint data; } exp_t;
   exp_t q[$];

   int n_assert = 0;
   int n_fail   = 0;
   bit mon_en   = 0;

   // Model state: 0 = idle, 1 = armed, 2 = measuring.
   int     m_state, m_idle;
   longint m_rt, m_upd, m_rdata;
   longint m_evt[NEV];
   longint m_snap[NIDX];
   bit     m_pend, m_snapv, m_trig;

   task automatic chk(string nm, longint act, longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint sat(longint v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic model_step();
      bit lat;
      int ns;
      exp_t e;
      if (!rst_n || clear) begin
         m_state = 0; m_idle = 0; m_rt = 0; m_upd = 0; m_rdata = 0;
         m_pend = 0; m_snapv = 0; m_trig = 0;
         for (int k = 0; k < NEV; k++) m_evt[k] = 0;
         for (int i = 0; i < NIDX; i++) m_snap[i] = 0;
      end else begin
         if (rd_req) begin
            if (int'(rd_idx) >= NIDX) begin e.err = 1; e.data = 0; end
            else begin e.err = 0; e.data = m_snap[rd_idx]; end
            q.push_back(e);
            m_rdata = e.data;
         end
         lat = m_pend && (m_idle >= 2) && !vinsn;
         if (m_state == 2) begin
            m_rt = sat(m_rt + 1);
            for (int k = 0; k < NEV; k++) if (ev[k]) m_evt[k] = sat(m_evt[k] + 1);
         end
         if (lat) begin
            m_upd = sat(m_upd + 1);
            m_snap[0] = m_rt;
            for (int k = 0; k < NEV; k++) m_snap[1 + k] = m_evt[k];
            m_snap[NIDX - 1] = m_upd;
            m_snapv = 1;
            m_pend = 0;
         end
         if (vinsn) m_pend = 1;
         m_idle = ara_idle ? ((m_idle >= 2) ? 2 : m_idle + 1) : 0;
         case (m_state)
            0:       ns = sw_en ? 1 : 0;
            1:       ns = !sw_en ? 0 : (vinsn ? 2 : 1);
            default: ns = (!sw_en && ara_idle) ? 0 : 2;
         endcase
         m_trig = (m_state == 1 && ns == 2) || (m_state == 2 && ns == 0);
         m_state = ns;
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("rd_valid", rd_valid, q.size() != 0);
         if (rd_valid && q.size() != 0) begin
            e = q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_err", rd_err, e.err);
         end else if (!rd_valid) begin
            chk("rd_hold", rd_data, m_rdata);
            chk("rd_err_idle", rd_err, 0);
         end
         chk("window_active", win, m_state == 2);
         chk("snapshot_valid", snapv, m_snapv);
`ifdef ARA_PERF_TRIGGER_EN
         chk("trigger", trig, m_trig);
`else
         chk("trigger", trig, 0);
`endif
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed read with a fixed expectation, on top of the scoreboard.
   task automatic read_exp(string nm, int idx, longint d, bit err);
      rd_req = 1; rd_idx = IW'(idx);
      cyc(1);
      rd_req = 0;
      chk({nm, "_data"}, rd_data, d);
      chk({nm, "_err"}, rd_err, err);
   endtask

   task automatic open_window();
      sw_en = 1; ara_idle = 1; cyc(2);
      vinsn = 1; ara_idle = 0; cyc(1);
      vinsn = 0;
   endtask

   initial begin
      rst_n = 0; sw_en = 0; vinsn = 0; ara_idle = 1; clear = 0;
      rd_req = 0; rd_idx = '0; ev = '0;
      cyc(2);
      mon_en = 1;
      chk("reset_win", win, 0);
      chk("reset_snapv", snapv, 0);
      chk("reset_rd_data", rd_data, 0);
      rst_n = 1;

      // Dispatch in cycle 10, busy 10..29, drain recognised in cycle 32.
      sw_en = 1; cyc(10);
      vinsn = 1; ara_idle = 0; cyc(1);
      vinsn = 0; cyc(19);
      ara_idle = 1; cyc(2);
      chk("snapv_before_drain", snapv, 0);
      cyc(1);
      chk("snapv_after_drain", snapv, 1);
      read_exp("plan_runtime", 0, 22, 0);
      read_exp("plan_updcnt", NEV + 1, 1, 0);
      cyc(5);
      chk("win_still_on", win, 1);
      sw_en = 0; cyc(1);
      chk("win_falls", win, 0);
`ifdef ARA_PERF_TRIGGER_EN
      chk("trig_close", trig, 1);
`else
      chk("trig_close", trig, 0);
`endif
      cyc(1);
      chk("trig_one_cycle", trig, 0);

      // Events counted only while measuring.
      clear = 1; cyc(1); clear = 0;
      sw_en = 1; cyc(1);
      ev = 3'b010; cyc(3);
      ev = 3'b000; vinsn = 1; ara_idle = 0; cyc(1);
      vinsn = 0; ev = 3'b010; cyc(5);
      ev = 3'b000; ara_idle = 1; cyc(4);
      read_exp("evt1", 2, 5, 0);
      read_exp("evt_updcnt", NEV + 1, 1, 0);

      // Dispatch with software disabled: snapshot still taken, runtime stays 0.
      clear = 1; sw_en = 0; cyc(1); clear = 0;
      vinsn = 1; cyc(1); vinsn = 0; cyc(3);
      chk("swoff_win", win, 0);
      chk("swoff_snapv", snapv, 1);
      read_exp("swoff_runtime", 0, 0, 0);
      read_exp("swoff_updcnt", NEV + 1, 1, 0);

      // Long window saturates the runtime counter; then out-of-range reads.
      clear = 1; cyc(1); clear = 0;
      open_window();
      cyc(1100);
      ara_idle = 1; cyc(4);
      read_exp("sat_runtime", 0, MAXV, 0);
      read_exp("oob_first", NEV + 2, 0, 1);
      read_exp("oob_last", 7, 0, 1);

      // clear mid-window with a pending drain discards everything.
      vinsn = 1; ara_idle = 0; cyc(1);
      vinsn = 0; cyc(3);
      clear = 1; cyc(1); clear = 0; sw_en = 0;
      chk("clear_win", win, 0);
      chk("clear_snapv", snapv, 0);
      for (int i = 0; i < NIDX; i++) read_exp("clear_read", i, 0, 0);

      // Same with reset.
      open_window();
      cyc(3); ara_idle = 1; cyc(4);
      vinsn = 1; ara_idle = 0; cyc(1); vinsn = 0; cyc(3);
      rst_n = 0; cyc(1); rst_n = 1; sw_en = 0;
      chk("rst_win", win, 0);
      chk("rst_snapv", snapv, 0);
      read_exp("rst_runtime", 0, 0, 0);
      read_exp("rst_updcnt", NEV + 1, 0, 0);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         clear = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) sw_en = ~sw_en;
         vinsn = ($urandom_range(0, 9) == 0);
         if (vinsn) ara_idle = 0;
         else if ($urandom_range(0, 5) == 0) ara_idle = ~ara_idle;
         ev = NEV'($urandom);
         rd_req = ($urandom_range(0, 9) < 4);
         rd_idx = IW'($urandom_range(0, 7));
         cyc(1);
      end
      rst_n = 1; clear = 0; rd_req = 0; vinsn = 0;
      cyc(3);
      chk("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ara_perf_window_ctrl.md
Name: ara_perf_window_ctrl

Overview:
- Measurement-window controller for Ara's vector runtime and CVA6 stall counters.
- Opens a window on the first vector dispatch while software enable is high, and keeps counting until software disables it and Ara is idle.
- Latches snapshots whenever the vector pipeline drains, and serves them to software via a 1-cycle read port.
- Sits in the SoC next to the control registers. Inputs come from the accelerator request, Ara idle and CVA6 perf-event signals.

Parameters:
NrEvents, 3, number of event counters (dcache stall, icache stall, sb full, ...)
CntWidth, 64, width of every counter and snapshot
IdleHold, 2, consecutive idle cycles (>=1) needed before a drain is recognised
IdxWidth, $clog2(NrEvents+2), read index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
sw_en_i  in  1  software counter enable (hw_cnt_en)
vinsn_valid_i  in  1  vector instruction dispatched to Ara this cycle
ara_idle_i  in  1  Ara idle
event_i  in  NrEvents  per-cycle perf event strobes
clear_i  in  1  synchronous clear of counters, snapshots and FSM
rd_req_i  in  1  snapshot read request
rd_idx_i  in  IdxWidth  0=runtime, 1..NrEvents=events, NrEvents+1=update count
rd_valid_o  out  1  read data valid
rd_data_o  out  CntWidth  read data
rd_err_o  out  1  index out of range
window_active_o  out  1  counters enabled (state RUN)
snapshot_valid_o  out  1  at least one snapshot latched since reset/clear
trigger_o  out  1  window open/close pulse (see Optional Feature)

Behaviour:
- Reset: all of the following are 0, and the FSM is in IDLE.
  - Outputs: rd_valid_o, rd_data_o, rd_err_o, window_active_o, snapshot_valid_o, trigger_o.
  - Internal: all counters, snapshots, pending flag and idle counter.
- Reset mid-window: discards all state with no snapshot taken.
- FSM:
  - IDLE->ARMED when sw_en_i=1.
  - ARMED->IDLE when sw_en_i=0.
  - ARMED->RUN when sw_en_i & vinsn_valid_i.
  - RUN stays while sw_en_i | !ara_idle_i.
  - RUN->IDLE when !sw_en_i & ara_idle_i.
- Simultaneous ARMED exit: sw_en_i falling and vinsn_valid_i in the same cycle -> ARMED->IDLE.
- Runtime counter: +1 every cycle in state RUN. The first increment is the cycle after the dispatch.
- Event counter k: +1 in cycles where state==RUN && event_i[k]=1.
- All counters saturate at all-ones, with no wrap.
- Idle counter: +1 while ara_idle_i (saturating at IdleHold); reset to 0 when !ara_idle_i.
- Drained = idle counter>=IdleHold.
- Pending flag:
  - Set on any vinsn_valid_i, in any state.
  - When pending & drained & !vinsn_valid_i:
    - copy runtime and events into the snapshots, registered next cycle;
    - increment the update count (saturating);
    - clear pending;
    - set snapshot_valid_o.
  - If vinsn_valid_i and the drain condition coincide: pending stays set and no snapshot is taken.
- Snapshots are never live counters; reads always return the last latched value.
- Read port:
  - rd_req_i in cycle N -> rd_valid_o=1 in cycle N+1, with rd_data_o=snapshot[rd_idx_i].
  - Idx > NrEvents+1 -> rd_data_o=0 and rd_err_o=1 for that cycle.
  - Back-to-back requests are accepted every cycle.
  - Outside valid cycles, rd_data_o holds its last value.
- A read in the same cycle as a latch returns the old snapshot.
- clear_i has priority over everything except reset and behaves identically to reset.

Optional Feature:
- Macro: ARA_PERF_TRIGGER_EN.
- Defined: trigger_o pulses high for exactly 1 cycle on ARMED->RUN and on RUN->IDLE. This drives the testbench VCD dump on/off.
- Undefined: trigger_o is tied 0 and the edge-detect logic is removed. The port list is unchanged.

Decomposition:
- ara_perf_pkg:
  - state enum perf_state_e {IDLE, ARMED, RUN};
  - cnt_t (logic [CntWidth-1:0]);
  - read-index localparams IdxRuntime=0, IdxEvt0=1, IdxUpdCnt(NrEvents).
- Sub-module ara_sat_counter (width param; en, clr, saturate at max).
  - Instantiated for runtime, each event and the update count.

Test Plan:
- sw_en_i=1; vinsn_valid_i pulse at cycle 10; ara_idle_i=0 for cycles 10..29 then 1; IdleHold=2; sw_en_i=1 throughout. Required:
  - snapshot latched at cycle 32;
  - read idx0=22, idx NrEvents+1 (update count)=1;
  - window_active_o stays 1.
- Same run, then sw_en_i=0 at cycle 40 with Ara idle -> window_active_o falls at cycle 41; trigger_o pulses at cycle 41 (macro on) or stays 0 (macro off).
- event_i[1]=1 for 5 cycles inside RUN and 3 cycles in ARMED -> snapshot idx2=5.
- sw_en_i=0 throughout, vinsn_valid_i pulses -> window_active_o=0; snapshot taken with runtime=0; update count=1.
- Force runtime to all-ones-2, run 10 cycles -> snapshot reads all-ones. Then read idx NrEvents+2 -> rd_err_o=1 and rd_data_o=0.
- clear_i mid-RUN while pending -> next cycle FSM is IDLE, snapshot_valid_o=0, all reads 0. rst_ni low mid-RUN gives the same result.
